eth_rx_mac: RTL and testbench
=============================

Name: eth_rx_mac

Overview:
- Receive MAC framer that consumes the GMII byte stream produced by the RGMII receive stage (gmii_rx_dv / gmii_rxd).
- Finds preamble/SFD and strips it, strips the 4-byte FCS, and checks CRC-32 and frame length.
- Delivers the frame bytes (DA through last payload byte) to the UDP/IP receive logic, followed by a one-cycle end-of-frame status.
- Runs entirely in the GMII receive clock domain.

Parameters:
- BOARD_MAC, 48'h00_11_22_33_44_55: local station address; used only with the optional filter.
- MIN_FRAME, 64: minimum legal frame length in bytes, DA..FCS inclusive.
- MAX_FRAME, 1518: maximum legal frame length in bytes, DA..FCS inclusive.

Ports:
- clk  input  1  GMII receive clock (driven by gmii_rx_clk)
- rst  input  1  reset; one clock, synchronous, active-high
- gmii_rx_dv  input  1  GMII receive data valid
- gmii_rxd  input  8  GMII receive data
- rx_valid  output  1  rx_data holds a frame byte this cycle
- rx_data  output  8  frame byte, DA first, FCS excluded
- rx_sof  output  1  high with the first rx_valid byte of a frame
- rx_done  output  1  one-cycle end-of-frame status strobe
- rx_good  output  1  qualifies rx_done: frame error-free
- rx_err  output  3  qualifies rx_done: [0] CRC, [1] length, [2] DA mismatch
- rx_len  output  11  qualifies rx_done: bytes delivered (total minus 4)

Behaviour:
- Reset: all outputs 0; FSM to IDLE; CRC register all-ones; counters 0. A frame in progress is abandoned with no rx_done.
- Inputs are registered once before any decoding.
- FSM states: IDLE, PREAMBLE, DATA, DROP, DONE.
- IDLE:
  - dv=1 and byte 0x55 -> PREAMBLE, with the 0x55 count set to 1.
  - dv=1 and any other byte -> DROP, silent (no rx_done).
- PREAMBLE:
  - 0x55 -> count+1; an 8th consecutive 0x55 -> silent DROP.
  - 0xD5 -> DATA; CRC initialised to 0xFFFFFFFF; byte count = 0.
  - Any other byte -> silent DROP.
  - dv=0 -> IDLE, no output.
- DATA:
  - Each byte updates the reflected CRC-32 (poly 0xEDB88320, LSB first, no final XOR) and increments an 11-bit count (saturates at 2047).
  - Each byte enters a 4-deep delay line. A byte is emitted on rx_data/rx_valid only once 4 newer bytes have entered, so the FCS is never output.
  - Byte k appears at the outputs 2 cycles after byte k+4 is presented on gmii_rxd.
  - rx_sof accompanies byte 0.
  - count exceeds MAX_FRAME -> DROP (non-silent). rx_valid stops immediately; the length error is latched.
  - dv=0 -> DONE.
- DROP:
  - Waits for dv=0.
  - Non-silent: then -> DONE with rx_err[1]=1.
  - Silent: then -> IDLE.
- DONE:
  - One cycle; emits rx_done, then -> IDLE.
  - rx_done occurs 3 cycles after the first cycle dv=0 is presented.
  - rx_err[0] = final CRC register != 0xDEBB20E3.
  - rx_err[1] = count < MIN_FRAME or count > MAX_FRAME.
  - rx_good = (rx_err == 0).
  - rx_len = count - 4, saturating at 0.
  - If no byte was emitted (count <= 4), the frame is silent: no rx_done.
- rx_good, rx_err and rx_len are valid only while rx_done=1; they are 0 otherwise.
- rx_valid is never high in the same cycle as rx_done.
- Back-to-back frames: a new preamble is accepted on the first dv=1 cycle after dv=0. The previous frame's rx_done still issues, and the delay line and CRC of the new frame are independent of it.
- A dv=0 gap inside DATA ends the frame; there is no resumption.

Optional Feature:
- Macro: ETH_RX_MAC_FILTER_EN.
- Defined:
  - The first 6 received bytes are compared with BOARD_MAC and with FF:FF:FF:FF:FF:FF.
  - If neither matches, rx_err[2]=1 at rx_done and rx_good=0. Data delivery is unchanged.
- Undefined: no comparator is built and rx_err[2] is tied 0.

Test Plan:
- Legal 64-byte broadcast frame: 7x0x55, 0xD5, 60 bytes, valid FCS -> 60 rx_valid bytes; rx_sof on the first (0xFF); rx_done with rx_good=1, rx_err=0, rx_len=60.
- Same frame with one FCS bit flipped -> 60 bytes delivered; rx_done with rx_good=0, rx_err=3'b001, rx_len=60.
- Runt: 40 bytes with valid FCS -> 36 bytes delivered; rx_done with rx_err=3'b010, rx_len=36.
- Oversize: 1530-byte frame -> rx_valid stops after 1515 bytes; rx_done once dv falls, with rx_err[1]=1.
- Preamble 0x55,0x55,0x12,... -> no rx_valid and no rx_done. Then assert rst mid-DATA of the next frame -> outputs 0 and no rx_done; the following clean frame is received good.
- ETH_RX_MAC_FILTER_EN defined, BOARD_MAC default: DA 00:11:22:33:44:55 -> rx_good=1. DA 00:11:22:33:44:56 -> rx_err=3'b100, rx_good=0.

Source files
------------

// File: rtl/eth_rx_mac.sv
// GMII receive framer: strips preamble/SFD and FCS, checks CRC-32 and frame length.
// Define ETH_RX_MAC_FILTER_EN to build the destination-address filter (rx_err[2]).
module eth_rx_mac #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter int          MIN_FRAME = 64,
    parameter int          MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_sof,
    output logic        rx_done,
    output logic        rx_good,
    output logic [2:0]  rx_err,
    output logic [10:0] rx_len
);

    localparam logic [2:0]  ST_IDLE     = 3'd0;
    localparam logic [2:0]  ST_PREAMBLE = 3'd1;
    localparam logic [2:0]  ST_DATA     = 3'd2;
    localparam logic [2:0]  ST_DROP     = 3'd3;
    localparam logic [2:0]  ST_DONE     = 3'd4;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

    logic            dv_r;
    logic [7:0]      rxd_r;
    logic [2:0]      state_r;
    logic [2:0]      pre_cnt_r;
    logic            loud_r;
    logic [10:0]     count_r;
    logic [31:0]     crc_r;
    logic [3:0][7:0] dly_r;

    logic [31:0]     crc_next_s;
    logic [10:0]     count_inc_s;
    logic [10:0]     len_s;
    logic [2:0]      err_s;
    logic            sfd_s;
    logic            take_s;
    logic            da_miss_s;

    // Next-value helpers shared by the FSM and the address filter
    always_comb begin
        crc_next_s  = crc32_byte(crc_r, rxd_r);
        count_inc_s = (count_r == 11'h7FF) ? count_r : count_r + 11'd1;
        if (count_r > 11'd4) len_s = count_r - 11'd4;
        else                 len_s = 11'd0;
        sfd_s  = (state_r == ST_PREAMBLE) && dv_r && (rxd_r == 8'hD5);
        take_s = (state_r == ST_DATA) && dv_r && (count_r <= MAX_LEN);
        err_s  = {da_miss_s, (count_r < MIN_LEN) || (count_r > MAX_LEN), crc_r != CRC_RESIDUE};
    end

`ifdef ETH_RX_MAC_FILTER_EN
    logic       da_mine_r;
    logic       da_bcast_r;
    logic [7:0] mac_byte_s;

    // Station-address byte expected at the current DA position
    always_comb begin
        case (count_r[2:0])
            3'd0:    mac_byte_s = BOARD_MAC[47:40];
            3'd1:    mac_byte_s = BOARD_MAC[39:32];
            3'd2:    mac_byte_s = BOARD_MAC[31:24];
            3'd3:    mac_byte_s = BOARD_MAC[23:16];
            3'd4:    mac_byte_s = BOARD_MAC[15:8];
            3'd5:    mac_byte_s = BOARD_MAC[7:0];
            default: mac_byte_s = 8'h00;
        endcase
    end

    // Running DA match against the station address and broadcast
    always_ff @(posedge clk) begin
        if (rst) begin
            da_mine_r  <= 1'b0;
            da_bcast_r <= 1'b0;
        end else if (sfd_s) begin
            da_mine_r  <= 1'b1;
            da_bcast_r <= 1'b1;
        end else if (take_s && (count_r < 11'd6)) begin
            da_mine_r  <= da_mine_r & (rxd_r == mac_byte_s);
            da_bcast_r <= da_bcast_r & (rxd_r == 8'hFF);
        end
    end

    assign da_miss_s = !(da_mine_r || da_bcast_r);
`else
    logic filter_unused_s;
    assign filter_unused_s = ^BOARD_MAC;
    assign da_miss_s       = 1'b0;
`endif

    // Input register, framing FSM, delay line and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_r      <= 1'b0;
            rxd_r     <= 8'h00;
            state_r   <= ST_IDLE;
            pre_cnt_r <= 3'd0;
            loud_r    <= 1'b0;
            count_r   <= 11'd0;
            crc_r     <= 32'hFFFF_FFFF;
            dly_r     <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
            rx_sof    <= 1'b0;
            rx_done   <= 1'b0;
            rx_good   <= 1'b0;
            rx_err    <= 3'b000;
            rx_len    <= 11'd0;
        end else begin
            dv_r     <= gmii_rx_dv;
            rxd_r    <= gmii_rxd;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            rx_sof   <= 1'b0;
            rx_done  <= 1'b0;
            rx_good  <= 1'b0;
            rx_err   <= 3'b000;
            rx_len   <= 11'd0;
            case (state_r)
                // DONE also accepts the first byte of a back-to-back preamble
                ST_IDLE, ST_DONE: begin
                    if ((state_r == ST_DONE) && (count_r > 11'd4)) begin
                        rx_done <= 1'b1;
                        rx_err  <= err_s;
                        rx_good <= (err_s == 3'b000);
                        rx_len  <= len_s;
                    end
                    if (dv_r) begin
                        if (rxd_r == 8'h55) begin
                            state_r   <= ST_PREAMBLE;
                            pre_cnt_r <= 3'd1;
                        end else begin
                            state_r <= ST_DROP;
                            loud_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (!dv_r) begin
                        state_r <= ST_IDLE;
                    end else if (rxd_r == 8'h55) begin
                        if (pre_cnt_r == 3'd7) begin
                            state_r <= ST_DROP;
                            loud_r  <= 1'b0;
                        end else begin
                            pre_cnt_r <= pre_cnt_r + 3'd1;
                        end
                    end else if (sfd_s) begin
                        state_r <= ST_DATA;
                        crc_r   <= 32'hFFFF_FFFF;
                        count_r <= 11'd0;
                    end else begin
                        state_r <= ST_DROP;
                        loud_r  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (!dv_r) begin
                        state_r <= ST_DONE;
                    end else if (take_s) begin
                        crc_r   <= crc_next_s;
                        count_r <= count_inc_s;
                        dly_r   <= {dly_r[2:0], rxd_r};
                        if (count_r >= 11'd4) begin
                            rx_valid <= 1'b1;
                            rx_data  <= dly_r[3];
                            rx_sof   <= (count_r == 11'd4);
                        end
                    end else begin
                        state_r <= ST_DROP;
                        loud_r  <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (!dv_r) state_r <= loud_r ? ST_DONE : ST_IDLE;
                    else       state_r <= ST_DROP;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_mac.sv
// Self-checking bench for eth_rx_mac: random frames against a frame-level reference model.
module tb_eth_rx_mac;

    typedef logic [7:0] bq_t[$];

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;

    logic        clk = 1'b0;
    logic        rst;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_sof;
    logic        rx_done;
    logic        rx_good;
    logic [2:0]  rx_err;
    logic [10:0] rx_len;

    eth_rx_mac dut (
        .clk        (clk),
        .rst        (rst),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rxd   (gmii_rxd),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_sof     (rx_sof),
        .rx_done    (rx_done),
        .rx_good    (rx_good),
        .rx_err     (rx_err),
        .rx_len     (rx_len)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int dvlow_cyc;
    int b4_cyc;

    // Monitor: record delivered bytes, frame starts and end-of-frame status
    bq_t         cap_q;
    int          sof_pos_q[$];
    int          sof_cyc_q[$];
    logic        dq_good[$];
    logic [2:0]  dq_err[$];
    logic [10:0] dq_len[$];
    int          dq_cyc[$];
    int          overlap_cnt = 0;
    int          stray_cnt   = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_sof) begin
                sof_pos_q.push_back(cap_q.size());
                sof_cyc_q.push_back(cyc);
            end
            cap_q.push_back(rx_data);
        end else if (rx_sof) begin
            stray_cnt <= stray_cnt + 1;
        end
        if (rx_done) begin
            dq_good.push_back(rx_good);
            dq_err.push_back(rx_err);
            dq_len.push_back(rx_len);
            dq_cyc.push_back(cyc);
            if (rx_valid) overlap_cnt <= overlap_cnt + 1;
        end else if (rx_good || (rx_err != 3'b000) || (rx_len != 11'd0)) begin
            stray_cnt <= stray_cnt + 1;
        end
    end

    function automatic logic [31:0] fcs_of(input bq_t f, input int len);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ f[i][b]) ? ({1'b0, c[31:1]} ^ 32'hEDB8_8320) : {1'b0, c[31:1]};
        return ~c;
    endfunction

    // kind: 0 broadcast, 1 station address, 2 near-miss station address, 3 random unicast
    function automatic bq_t make_frame(input int n, input int kind, input int flip);
        bq_t         f;
        logic [47:0] da;
        logic [31:0] fcs;
        case (kind)
            0:       da = 48'hFFFF_FFFF_FFFF;
            1:       da = BOARD_MAC;
            2:       da = 48'h00_11_22_33_44_56;
            default: da = {8'h02, 8'($urandom), 32'($urandom)};
        endcase
        for (int i = 0; i < 6; i++) f.push_back(da[47 - 8 * i -: 8]);
        while (f.size() < n - 4) f.push_back(8'($urandom));
        fcs = fcs_of(f, n - 4);
        if (flip >= 0) fcs[flip] = ~fcs[flip];
        for (int i = 0; i < 4; i++) f.push_back(fcs[8 * i +: 8]);
        return f;
    endfunction

    // Reference model: bytes accepted stop one past the maximum legal length
    function automatic int model_deliv(input bq_t f);
        int acc;
        acc = (f.size() > 1519) ? 1519 : f.size();
        return (acc > 4) ? acc - 4 : 0;
    endfunction

    function automatic logic [2:0] model_err(input bq_t f);
        int          acc;
        logic [47:0] da;
        logic [2:0]  e;
        acc  = (f.size() > 1519) ? 1519 : f.size();
        e[0] = fcs_of(f, acc - 4) != {f[acc - 1], f[acc - 2], f[acc - 3], f[acc - 4]};
        e[1] = (acc < 64) || (acc > 1518);
        da   = {f[0], f[1], f[2], f[3], f[4], f[5]};
`ifdef ETH_RX_MAC_FILTER_EN
        e[2] = (da != BOARD_MAC) && (da != 48'hFFFF_FFFF_FFFF);
`else
        e[2] = (da == da) ? 1'b0 : 1'b1;
`endif
        return e;
    endfunction

    function automatic int count_mism(input bq_t f, input int base, input int deliv);
        int m;
        m = 0;
        if (cap_q.size() < base + deliv) return deliv + 1;
        for (int i = 0; i < deliv; i++)
            if (cap_q[base + i] !== f[i]) m++;
        return m;
    endfunction

    task automatic drive(input logic dv, input logic [7:0] d);
        @(posedge clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic send(input bq_t f);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        foreach (f[i]) begin
            drive(1'b1, f[i]);
            if (i == 4) b4_cyc = cyc;
        end
        drive(1'b0, 8'h00);
        dvlow_cyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        n_checks++;
        if ({rx_valid, rx_data, rx_sof, rx_done, rx_good, rx_err, rx_len} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {rx_valid, rx_data, rx_sof, rx_done, rx_good, rx_err, rx_len});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame();
        bq_t f;
        int  base, dn, sn, mism;
        f    = make_frame(64, 0, -1);
        base = cap_q.size();
        dn   = dq_len.size();
        sn   = sof_pos_q.size();
        send(f);
        idle(6);
        mism = count_mism(f, base, 60);
        n_checks++;
        if (mism != 0 || cap_q.size() - base != 60) begin
            n_fail++;
            $display("FAIL good_data: got %0d bytes/%0d mismatches, want 60/0", cap_q.size() - base, mism);
        end
        n_checks++;
        if (sof_pos_q.size() != sn + 1 || sof_pos_q[sn] != base || cap_q[base] !== 8'hFF) begin
            n_fail++;
            $display("FAIL good_sof: got %0d sofs at %0d byte %h, want 1 at %0d byte ff",
                     sof_pos_q.size() - sn, sof_pos_q[sn], cap_q[base], base);
        end
        n_checks++;
        if (sof_cyc_q[sn] - b4_cyc != 2) begin
            n_fail++;
            $display("FAIL good_data_latency: got %0d cycles, want 2", sof_cyc_q[sn] - b4_cyc);
        end
        n_checks++;
        if (dq_len.size() != dn + 1 || dq_good[dn] !== 1'b1 || dq_err[dn] !== 3'b000 || dq_len[dn] !== 11'd60) begin
            n_fail++;
            $display("FAIL good_status: got %0d dones good=%b err=%b len=%0d, want 1 good=1 err=000 len=60",
                     dq_len.size() - dn, dq_good[dn], dq_err[dn], dq_len[dn]);
        end
        n_checks++;
        if (dq_cyc[dn] - dvlow_cyc != 3) begin
            n_fail++;
            $display("FAIL good_done_latency: got %0d cycles, want 3", dq_cyc[dn] - dvlow_cyc);
        end
    endtask

    task automatic test_errors();
        bq_t        f;
        int         base, dn, mism, n, want;
        logic [2:0] want_err;
        for (int t = 0; t < 3; t++) begin
            n        = (t == 0) ? 64 : ((t == 1) ? 40 : 1530);
            f        = make_frame(n, 0, (t == 0) ? int'($urandom_range(0, 31)) : -1);
            want     = (t == 0) ? 60 : ((t == 1) ? 36 : 1515);
            want_err = (t == 0) ? 3'b001 : 3'b010;
            base     = cap_q.size();
            dn       = dq_len.size();
            send(f);
            idle(6);
            mism = count_mism(f, base, want);
            n_checks++;
            if (mism != 0 || cap_q.size() - base != want) begin
                n_fail++;
                $display("FAIL err%0d_data: got %0d bytes/%0d mismatches, want %0d/0", t, cap_q.size() - base, mism, want);
            end
            n_checks++;
            if (dq_len.size() != dn + 1 || dq_good[dn] !== 1'b0 || dq_len[dn] !== 11'(want) ||
                (t < 2 && dq_err[dn] !== want_err) || (t == 2 && dq_err[dn][1] !== 1'b1)) begin
                n_fail++;
                $display("FAIL err%0d_status: got %0d dones good=%b err=%b len=%0d, want 1 good=0 err=%b len=%0d",
                         t, dq_len.size() - dn, dq_good[dn], dq_err[dn], dq_len[dn], want_err, want);
            end
            n_checks++;
            if (dq_cyc[dn] - dvlow_cyc != 3) begin
                n_fail++;
                $display("FAIL err%0d_done_latency: got %0d cycles, want 3", t, dq_cyc[dn] - dvlow_cyc);
            end
        end
    endtask

    task automatic test_bad_preamble_and_reset();
        bq_t f;
        int  base, dn;
        base = cap_q.size();
        dn   = dq_len.size();
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h12);
        for (int i = 0; i < 12; i++) drive(1'b1, (i == 3) ? 8'hD5 : 8'($urandom));
        idle(8);
        n_checks++;
        if (cap_q.size() != base || dq_len.size() != dn) begin
            n_fail++;
            $display("FAIL bad_preamble: got %0d bytes %0d dones, want 0 0", cap_q.size() - base, dq_len.size() - dn);
        end
        f = make_frame(64, 0, -1);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < 20; i++) drive(1'b1, f[i]);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        dn         = dq_len.size();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rx_valid, rx_data, rx_sof, rx_done, rx_good, rx_err, rx_len} !== 26'd0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got %b, want all zero",
                     {rx_valid, rx_data, rx_sof, rx_done, rx_good, rx_err, rx_len});
        end
        base = cap_q.size();
        idle(8);
        n_checks++;
        if (cap_q.size() != base || dq_len.size() != dn) begin
            n_fail++;
            $display("FAIL midframe_reset_silent: got %0d bytes %0d dones, want 0 0", cap_q.size() - base, dq_len.size() - dn);
        end
        f    = make_frame(64, 1, -1);
        base = cap_q.size();
        dn   = dq_len.size();
        send(f);
        idle(6);
        n_checks++;
        if (count_mism(f, base, 60) != 0 || cap_q.size() - base != 60 || dq_len.size() != dn + 1 ||
            dq_good[dn] !== 1'b1 || dq_len[dn] !== 11'd60) begin
            n_fail++;
            $display("FAIL after_reset_frame: got %0d bytes good=%b len=%0d, want 60 good=1 len=60",
                     cap_q.size() - base, dq_good[dn], dq_len[dn]);
        end
    endtask

    task automatic test_filter();
        bq_t        f;
        int         dn;
        logic [2:0] want;
        for (int k = 1; k <= 2; k++) begin
`ifdef ETH_RX_MAC_FILTER_EN
            want = (k == 2) ? 3'b100 : 3'b000;
`else
            want = 3'b000;
`endif
            f  = make_frame(64, k, -1);
            dn = dq_len.size();
            send(f);
            idle(6);
            n_checks++;
            if (dq_len.size() != dn + 1 || dq_err[dn] !== want || dq_good[dn] !== (want == 3'b000)) begin
                n_fail++;
                $display("FAIL filter_da%0d: got err=%b good=%b, want err=%b good=%b",
                         k, dq_err[dn], dq_good[dn], want, want == 3'b000);
            end
        end
    endtask

    task automatic test_random();
        bq_t        f;
        int         base, dn, d, flip;
        logic [2:0] e;
        for (int t = 0; t < 10; t++) begin
            flip = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : -1;
            f    = make_frame(int'($urandom_range(30, 140)), int'($urandom_range(0, 3)), flip);
            d    = model_deliv(f);
            e    = model_err(f);
            base = cap_q.size();
            dn   = dq_len.size();
            send(f);
            idle(6);
            n_checks++;
            if (count_mism(f, base, d) != 0 || cap_q.size() - base != d || dq_len.size() != dn + 1 ||
                dq_err[dn] !== e || dq_good[dn] !== (e == 3'b000) || dq_len[dn] !== 11'(d)) begin
                n_fail++;
                $display("FAIL random%0d: got %0d bytes err=%b good=%b len=%0d, want %0d err=%b good=%b len=%0d",
                         t, cap_q.size() - base, dq_err[dn], dq_good[dn], dq_len[dn], d, e, e == 3'b000, d);
            end
        end
    endtask

    task automatic test_back_to_back();
        bq_t        fa, fb;
        int         base, dn, da, db, dla;
        logic [2:0] ea, eb;
        for (int t = 0; t < 3; t++) begin
            fa   = make_frame(int'($urandom_range(50, 100)), int'($urandom_range(0, 3)), -1);
            fb   = make_frame(int'($urandom_range(30, 100)), int'($urandom_range(0, 3)), -1);
            da   = model_deliv(fa);
            db   = model_deliv(fb);
            ea   = model_err(fa);
            eb   = model_err(fb);
            base = cap_q.size();
            dn   = dq_len.size();
            send(fa);
            dla = dvlow_cyc;
            send(fb);
            idle(6);
            n_checks++;
            if (count_mism(fa, base, da) != 0 || count_mism(fb, base + da, db) != 0 ||
                cap_q.size() - base != da + db) begin
                n_fail++;
                $display("FAIL b2b%0d_data: got %0d bytes, want %0d", t, cap_q.size() - base, da + db);
            end
            n_checks++;
            if (dq_len.size() != dn + 2 || dq_err[dn] !== ea || dq_len[dn] !== 11'(da) ||
                dq_err[dn + 1] !== eb || dq_len[dn + 1] !== 11'(db) || dq_cyc[dn] - dla != 3) begin
                n_fail++;
                $display("FAIL b2b%0d_status: got %0d dones err=%b/%b len=%0d/%0d lat=%0d, want 2 err=%b/%b len=%0d/%0d lat=3",
                         t, dq_len.size() - dn, dq_err[dn], dq_err[dn + 1], dq_len[dn], dq_len[dn + 1],
                         dq_cyc[dn] - dla, ea, eb, da, db);
            end
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (overlap_cnt != 0 || stray_cnt != 0) begin
            n_fail++;
            $display("FAIL protocol: got %0d valid/done overlaps and %0d stray qualifiers, want 0 0",
                     overlap_cnt, stray_cnt);
        end
    endtask

    initial begin
        rst        = 1'b1;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        test_reset();
        test_good_frame();
        test_errors();
        test_bad_preamble_and_reset();
        test_filter();
        test_random();
        test_back_to_back();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
